output_vc_credit_tracker: RTL and testbench
===========================================

Name: output_vc_credit_tracker

Overview:
Per-output-port tracker for downstream VC state and credits; one instance per non-local output port, feeding VC allocation and switch allocation. Holds a credit counter and an allocation state machine per downstream VC, and reports VC availability and credit readiness. Generalises the fixed-credit VC availability logic:
- Configurable buffer depth and VC count.
- Selectable VC-release mode (non-atomic or atomic).
- Sticky protocol-error detection.

Parameters:
NUM_VC, 4, number of downstream VCs on this output port (>=2)
BUF_DEPTH, 4, flit slots per downstream VC buffer; credits reset to this value (>=1)
ATOMIC_VC, 0, 0 = VC reusable once tail sent and >=1 credit; 1 = VC reusable only after all BUF_DEPTH credits returned
VC_BITS, $clog2(NUM_VC), derived VC index width
CNT_W, $clog2(BUF_DEPTH+1), derived credit counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
alloc_valid  in  1  VC allocator grants downstream VC alloc_vc to a new packet this cycle
alloc_vc  in  VC_BITS  VC being allocated
send_valid  in  1  switch traversal sends one flit on send_vc this cycle
send_vc  in  VC_BITS  VC of the sent flit
send_tail  in  1  sent flit is a tail (or single-flit packet)
credit_in  in  NUM_VC  per-VC credit increment from the downstream router, one credit per asserted bit
vc_avail  out  NUM_VC  VC free for allocation
has_credit  out  NUM_VC  VC counter non-zero (switch allocation may send)
vc_busy  out  NUM_VC  VC state is not IDLE
credit_count  out  NUM_VC*CNT_W  packed counters, VC v at bits [v*CNT_W +: CNT_W]
num_free_vcs  out  $clog2(NUM_VC+1)  popcount of vc_avail
err_flags  out  4  sticky: [0] send with zero credit, [1] send on non-ACTIVE VC, [2] alloc on non-IDLE VC, [3] credit overflow

Behaviour:
- Reset (reset low, async):
  - All counters = BUF_DEPTH; all states IDLE; err_flags = 0.
  - Outputs: vc_avail all 1, has_credit all 1, vc_busy all 0, num_free_vcs = NUM_VC.
- Per-VC states: IDLE, ACTIVE, DRAIN (DRAIN used only when ATOMIC_VC=1).
- IDLE -> ACTIVE on legal alloc (alloc_valid, alloc_vc==v, state IDLE).
- ACTIVE on legal send with send_tail:
  - ATOMIC_VC=0: -> IDLE.
  - ATOMIC_VC=1: -> IDLE if next count == BUF_DEPTH, else -> DRAIN.
- DRAIN -> IDLE in the cycle where next count == BUF_DEPTH.
- Counter update: next = count - legal_send + credit_in[v]. Send and credit in the same cycle leave the count unchanged.
- Legal send: send_valid, state ACTIVE, count > 0.
- Illegal send:
  - Counter and state unchanged.
  - Set err[0] if count==0; set err[1] if state != ACTIVE (both may set).
- Illegal alloc (state != IDLE): state unchanged, set err[2].
- Credit overflow (next > BUF_DEPTH): counter saturates at BUF_DEPTH, set err[3].
- Alloc and send on the same VC in the same cycle: the send sees the pre-alloc state (IDLE), so the send is illegal and sets err[1]; the alloc is applied normally.
- Alloc and send on different VCs in the same cycle: both processed independently.
- Output decode (combinational from registered state only; no input-to-output paths):
  - vc_avail[v] = IDLE && (ATOMIC_VC ? count==BUF_DEPTH : count>0).
  - has_credit[v] = count != 0.
  - vc_busy[v] = state != IDLE.
- Latency: every input effect is visible on outputs the cycle after the clock edge.
- err_flags are sticky until reset.
- Reset asserted mid-packet immediately returns every VC to IDLE with full credits.

Test Plan:
1. Reset (NUM_VC=4, BUF_DEPTH=4) -> vc_avail=1111, credit_count all 4, num_free_vcs=4, err_flags=0000.
2. Alloc VC2; send 4 flits on VC2, the last with tail, ATOMIC_VC=0 -> credit_count[2] 4,3,2,1,0; vc_avail[2]=0 after the tail (count 0); one credit_in[2] -> count 1, vc_avail[2]=1.
3. ATOMIC_VC=1: alloc VC1, send 2 flits (tail on the 2nd) -> state DRAIN, vc_avail[1]=0; credit_in[1] twice -> count 4, IDLE, vc_avail[1]=1 the next cycle.
4. VC0 ACTIVE, count 1: send_valid plus credit_in[0] in the same cycle -> count stays 1; next cycle a send leaves count 0; a further send -> err_flags[0]=1, count stays 0.
5. credit_in[3] while count=4 -> count stays 4, err_flags[3]=1, persists until reset.
6. Alloc VC0 twice in consecutive cycles -> second alloc sets err_flags[2]=1; reset low mid-stream -> all counts 4, err_flags=0000 asynchronously.

Source files
------------

// File: rtl/output_vc_credit_tracker.sv
// Downstream VC credit and allocation tracker for one router output port.
// Reports per-VC availability, credit readiness and sticky protocol errors.
module output_vc_credit_tracker #(
    parameter int NUM_VC    = 4,
    parameter int BUF_DEPTH = 4,
    parameter int ATOMIC_VC = 0,
    parameter int VC_BITS   = $clog2(NUM_VC),
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alloc_valid,
    input  logic [VC_BITS-1:0]            alloc_vc,
    input  logic                          send_valid,
    input  logic [VC_BITS-1:0]            send_vc,
    input  logic                          send_tail,
    input  logic [NUM_VC-1:0]             credit_in,
    output logic [NUM_VC-1:0]             vc_avail,
    output logic [NUM_VC-1:0]             has_credit,
    output logic [NUM_VC-1:0]             vc_busy,
    output logic [NUM_VC*CNT_W-1:0]       credit_count,
    output logic [$clog2(NUM_VC+1)-1:0]   num_free_vcs,
    output logic [3:0]                    err_flags,
    output logic [2*NUM_VC-1:0]           vc_state_dbg
);

    localparam int                NF_W   = $clog2(NUM_VC + 1);
    localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W:0]    FULL_W = (CNT_W + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } vc_state_t;

    vc_state_t          state_q [NUM_VC];
    vc_state_t          state_d [NUM_VC];
    logic [CNT_W-1:0]   cnt_q   [NUM_VC];
    logic [CNT_W-1:0]   cnt_d   [NUM_VC];
    logic [CNT_W:0]     sum     [NUM_VC];
    logic [NUM_VC-1:0]  alloc_hit;
    logic [NUM_VC-1:0]  send_hit;
    logic [NUM_VC-1:0]  send_ok;
    logic [3:0]         err_set;
    logic [3:0]         err_q;

    always_comb begin
        alloc_hit = '0;
        send_hit  = '0;
        send_ok   = '0;
        err_set   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            sum[v]     = '0;
            state_d[v] = state_q[v];
            cnt_d[v]   = cnt_q[v];
        end
        for (int v = 0; v < NUM_VC; v++) begin
            alloc_hit[v] = alloc_valid && (alloc_vc == VC_BITS'(v));
            send_hit[v]  = send_valid && (send_vc == VC_BITS'(v));
            // Send judged against the registered state, so a same-cycle alloc cannot legalise it.
            send_ok[v]   = send_hit[v] && (state_q[v] == ST_ACTIVE) && (cnt_q[v] != '0);
            if (send_hit[v] && (cnt_q[v] == '0))        err_set[0] = 1'b1;
            if (send_hit[v] && (state_q[v] != ST_ACTIVE)) err_set[1] = 1'b1;
            if (alloc_hit[v] && (state_q[v] != ST_IDLE))  err_set[2] = 1'b1;

            sum[v] = {1'b0, cnt_q[v]} - {{CNT_W{1'b0}}, send_ok[v]}
                                      + {{CNT_W{1'b0}}, credit_in[v]};
            if (sum[v] > FULL_W) begin
                cnt_d[v]   = FULL_C;
                err_set[3] = 1'b1;
            end else begin
                cnt_d[v] = sum[v][CNT_W-1:0];
            end

            case (state_q[v])
                ST_IDLE: begin
                    if (alloc_hit[v]) state_d[v] = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (send_ok[v] && send_tail) begin
                        if ((ATOMIC_VC != 0) && (cnt_d[v] != FULL_C)) state_d[v] = ST_DRAIN;
                        else                                           state_d[v] = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_d[v] == FULL_C) state_d[v] = ST_IDLE;
                end
                default: state_d[v] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v] <= ST_IDLE;
                cnt_q[v]   <= FULL_C;
            end
            err_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v] <= state_d[v];
                cnt_q[v]   <= cnt_d[v];
            end
            err_q <= err_q | err_set;
        end
    end

    always_comb begin
        vc_avail     = '0;
        has_credit   = '0;
        vc_busy      = '0;
        credit_count = '0;
        vc_state_dbg = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            vc_busy[v]    = (state_q[v] != ST_IDLE);
            has_credit[v] = (cnt_q[v] != '0);
            // Atomic mode only hands out a VC whose downstream buffer is completely empty.
            vc_avail[v]   = (state_q[v] == ST_IDLE) &&
                            ((ATOMIC_VC != 0) ? (cnt_q[v] == FULL_C) : (cnt_q[v] != '0));
            credit_count[v*CNT_W +: CNT_W] = cnt_q[v];
            vc_state_dbg[2*v +: 2]         = state_q[v];
        end
    end

    always_comb begin
        num_free_vcs = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            num_free_vcs = num_free_vcs + NF_W'(vc_avail[v]);
        end
    end

    assign err_flags = err_q;

endmodule

// File: tb/tb_output_vc_credit_tracker.sv
// Directed bench for output_vc_credit_tracker: a non-atomic and an atomic instance
// share stimulus; a vector table covers the non-atomic flow, hand sequences the rest.
module tb_output_vc_credit_tracker;

  logic        clk;
  logic        reset;
  logic        alloc_valid;
  logic [1:0]  alloc_vc;
  logic        send_valid;
  logic [1:0]  send_vc;
  logic        send_tail;
  logic [3:0]  credit_in;

  logic [3:0]  n_avail, n_hcred, n_busy, n_err;
  logic [11:0] n_cnt;
  logic [2:0]  n_free;
  logic [7:0]  n_dbg;
  logic [3:0]  a_avail, a_hcred, a_busy, a_err;
  logic [11:0] a_cnt;
  logic [2:0]  a_free;
  logic [7:0]  a_dbg;

  int checks = 0;
  int errors = 0;

  output_vc_credit_tracker #(.NUM_VC(4), .BUF_DEPTH(4), .ATOMIC_VC(0)) dut_n (
    .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_vc(alloc_vc),
    .send_valid(send_valid), .send_vc(send_vc), .send_tail(send_tail), .credit_in(credit_in),
    .vc_avail(n_avail), .has_credit(n_hcred), .vc_busy(n_busy), .credit_count(n_cnt),
    .num_free_vcs(n_free), .err_flags(n_err), .vc_state_dbg(n_dbg)
  );

  output_vc_credit_tracker #(.NUM_VC(4), .BUF_DEPTH(4), .ATOMIC_VC(1)) dut_a (
    .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_vc(alloc_vc),
    .send_valid(send_valid), .send_vc(send_vc), .send_tail(send_tail), .credit_in(credit_in),
    .vc_avail(a_avail), .has_credit(a_hcred), .vc_busy(a_busy), .credit_count(a_cnt),
    .num_free_vcs(a_free), .err_flags(a_err), .vc_state_dbg(a_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [1:0]  avc;
    logic        sv;
    logic [1:0]  svc;
    logic        st;
    logic [3:0]  cr;
    logic [11:0] e_cnt;
    logic [3:0]  e_avail;
    logic [3:0]  e_busy;
    logic [3:0]  e_err;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [11:0] pk(input int c3, input int c2, input int c1, input int c0);
    pk = {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  function automatic logic [3:0] hc_of(input logic [11:0] c);
    logic [3:0] r;
    for (int v = 0; v < 4; v++) r[v] = (c[v*3 +: 3] != 3'd0);
    return r;
  endfunction

  function automatic logic [2:0] pop4(input logic [3:0] b);
    return 3'(b[0]) + 3'(b[1]) + 3'(b[2]) + 3'(b[3]);
  endfunction

  function automatic vec_t mk(input logic av, input logic [1:0] avc, input logic sv,
                              input logic [1:0] svc, input logic st, input logic [3:0] cr,
                              input logic [11:0] e_cnt, input logic [3:0] e_avail,
                              input logic [3:0] e_busy, input logic [3:0] e_err);
    vec_t r;
    r.av = av; r.avc = avc; r.sv = sv; r.svc = svc; r.st = st; r.cr = cr;
    r.e_cnt = e_cnt; r.e_avail = e_avail; r.e_busy = e_busy; r.e_err = e_err;
    return r;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic av, input logic [1:0] avc, input logic sv,
                       input logic [1:0] svc, input logic st, input logic [3:0] cr);
    alloc_valid = av; alloc_vc = avc; send_valid = sv; send_vc = svc;
    send_tail = st; credit_in = cr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 4'b0000);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_n_full(input string tag, input logic [11:0] cnt, input logic [3:0] avail,
                            input logic [3:0] busy, input logic [3:0] err);
    chk({tag, ".cnt"},   32'(n_cnt),   32'(cnt));
    chk({tag, ".avail"}, 32'(n_avail), 32'(avail));
    chk({tag, ".busy"},  32'(n_busy),  32'(busy));
    chk({tag, ".hcred"}, 32'(n_hcred), 32'(hc_of(cnt)));
    chk({tag, ".free"},  32'(n_free),  32'(pop4(avail)));
    chk({tag, ".err"},   32'(n_err),   32'(err));
  endtask

  initial begin
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 4'b0000);

    //               av   avc  sv   svc  st   cr       cnt(3,2,1,0)  avail    busy     err
    tbl[0]  = mk(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 4'b0000, pk(4,4,4,4), 4'b1011, 4'b0100, 4'b0000);
    tbl[1]  = mk(1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 4'b0000, pk(4,3,4,4), 4'b1011, 4'b0100, 4'b0000);
    tbl[2]  = mk(1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 4'b0000, pk(4,2,4,4), 4'b1011, 4'b0100, 4'b0000);
    tbl[3]  = mk(1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 4'b0000, pk(4,1,4,4), 4'b1011, 4'b0100, 4'b0000);
    tbl[4]  = mk(1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 4'b0000, pk(4,0,4,4), 4'b1011, 4'b0000, 4'b0000);
    tbl[5]  = mk(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 4'b0100, pk(4,1,4,4), 4'b1111, 4'b0000, 4'b0000);
    tbl[6]  = mk(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 4'b0000, pk(4,1,4,4), 4'b1110, 4'b0001, 4'b0000);
    tbl[7]  = mk(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 4'b0000, pk(4,1,4,3), 4'b1110, 4'b0001, 4'b0000);
    tbl[8]  = mk(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 4'b0000, pk(4,1,4,2), 4'b1110, 4'b0001, 4'b0000);
    tbl[9]  = mk(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 4'b0000, pk(4,1,4,1), 4'b1110, 4'b0001, 4'b0000);
    tbl[10] = mk(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 4'b0001, pk(4,1,4,1), 4'b1110, 4'b0001, 4'b0000);
    tbl[11] = mk(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 4'b0000, pk(4,1,4,0), 4'b1110, 4'b0001, 4'b0000);
    tbl[12] = mk(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 4'b0000, pk(4,1,4,0), 4'b1110, 4'b0001, 4'b0001);
    tbl[13] = mk(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 4'b1000, pk(4,1,4,0), 4'b1110, 4'b0001, 4'b1001);
    tbl[14] = mk(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 4'b0000, pk(4,1,4,0), 4'b1110, 4'b0001, 4'b1001);
    tbl[15] = mk(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 4'b0000, pk(4,1,4,0), 4'b1100, 4'b0011, 4'b1001);
    tbl[16] = mk(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 4'b0000, pk(4,1,4,0), 4'b1100, 4'b0011, 4'b1101);
    tbl[17] = mk(1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 4'b0000, pk(4,1,4,0), 4'b1000, 4'b0111, 4'b1111);

    // reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_n_full("reset", pk(4,4,4,4), 4'b1111, 4'b0000, 4'b0000);
    chk("reset.a_avail", 32'(a_avail), 32'hF);
    chk("reset.a_free", 32'(a_free), 32'd4);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // non-atomic table
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].av, tbl[i].avc, tbl[i].sv, tbl[i].svc, tbl[i].st, tbl[i].cr);
      step();
      chk_n_full($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_avail, tbl[i].e_busy, tbl[i].e_err);
    end

    // asynchronous reset mid-stream, checked before any clock edge
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_n_full("async_rst", pk(4,4,4,4), 4'b1111, 4'b0000, 4'b0000);
    chk("async_rst.a_err", 32'(a_err), 32'd0);
    do_reset();

    // atomic mode: tail with credits outstanding drains before reuse
    drive(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 4'b0000);
    step();
    chk("atom.alloc.avail", 32'(a_avail), 32'b1101);
    drive(1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 4'b0000);
    step();
    drive(1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 4'b0000);
    step();
    chk("atom.drain.cnt",   32'(a_cnt),   32'(pk(4,4,2,4)));
    chk("atom.drain.busy",  32'(a_busy),  32'b0010);
    chk("atom.drain.avail", 32'(a_avail), 32'b1101);
    chk("atom.drain.dbg",   32'(a_dbg[3:2]), 32'd2);
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 4'b0010);
    step();
    chk("atom.cr1.cnt",   32'(a_cnt),   32'(pk(4,4,3,4)));
    chk("atom.cr1.avail", 32'(a_avail), 32'b1101);
    chk("atom.cr1.busy",  32'(a_busy),  32'b0010);
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 4'b0010);
    step();
    chk("atom.cr2.cnt",   32'(a_cnt),   32'(pk(4,4,4,4)));
    chk("atom.cr2.avail", 32'(a_avail), 32'b1111);
    chk("atom.cr2.busy",  32'(a_busy),  32'b0000);
    chk("atom.cr2.free",  32'(a_free),  32'd4);
    chk("atom.cr2.err",   32'(a_err),   32'd0);

    // atomic mode: tail plus same-cycle credit keeps buffer full, so straight to IDLE
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 4'b0000);
    step();
    drive(1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 4'b0001);
    step();
    chk("atom.tailcr.cnt",   32'(a_cnt),   32'(pk(4,4,4,4)));
    chk("atom.tailcr.busy",  32'(a_busy),  32'b0000);
    chk("atom.tailcr.avail", 32'(a_avail), 32'b1111);
    chk("atom.tailcr.err",   32'(a_err),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
